// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the ARM-subset core: instruction FSM, NZCV flag
// register, conditional execution and datapath control decode.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mem_ready,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q;
    logic       cond_pass;
    logic       is_cmp;
    logic       flags_we;
    logic [1:0] alu_ctl;
    logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;

    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags_q;

    assign is_cmp   = (funct[4:1] == 4'b1010);
    assign flags_we = ((state_q == S_EXECUTER) || (state_q == S_EXECUTEI))
                      && (funct[0] || is_cmp);

    // State and flag registers; flags only load on the execute exit edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (flags_we) flags_q <= alu_flags;
        end
    end

    // Condition-code evaluation against the stored flags
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !c_f || z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctl = 2'b00;
        case (funct[4:1])
            4'b0010: alu_ctl = 2'b01;
            4'b1010: alu_ctl = 2'b01;
            4'b0000: alu_ctl = 2'b10;
            4'b1100: alu_ctl = 2'b11;
            default: alu_ctl = 2'b00;
        endcase
    end

    // Next-state logic; unused codes fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!cond_pass || (op == 2'b11)) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        2'b01:   state_d = S_MEMADR;
                        2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                        default: state_d = S_BRANCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUControl  = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:  ALUSrcB = 2'b01;
            S_MEMREAD: AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                pc_write_c  = (rd == 4'd15);
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECUTER: ALUControl = alu_ctl;
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_ctl;
            end
            S_ALUWB: begin
                reg_write_c = !is_cmp;
                pc_write_c  = !is_cmp && (rd == 4'd15);
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pc_write_c = 1'b1;
            end
            default: ;
        endcase
    end

    // State-independent immediate and register-port selects
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            2'b01:   ImmSrc = 2'b01;
            2'b10:   ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign RegSrc = {(op == 2'b01) && !funct[0], (op == 2'b10)};

    // Write enables are held off asynchronously while reset is asserted
    assign PCWrite  = pc_write_c  & reset_n;
    assign IRWrite  = ir_write_c  & reset_n;
    assign MemWrite = mem_write_c & reset_n;
    assign RegWrite = reg_write_c & reset_n;
    assign Flags    = flags_q;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected control
// vectors are queued per instruction and compared by a negedge monitor.
module tb_multicycle_controller;

    logic       clk;
    logic       reset_n;
    logic       mem_ready;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0] Flags, State;

    int errors = 0;
    int checks = 0;

    logic [18:0] sb_q[$];
    string       name_q[$];
    logic [18:0] exp_v;
    string       exp_n;
    logic [18:0] obs;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .mem_ready(mem_ready),
        .cond(cond), .op(op), .funct(funct), .rd(rd), .alu_flags(alu_flags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {State, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                  ResultSrc, ALUSrcB, ALUControl, Flags};

    // {state, pcw, irw, memw, regw, adrsrc, resultsrc, alusrcb, aluctl, flags}
    function automatic logic [18:0] pk(input logic [3:0] st, input logic pcw,
            input logic irw, input logic memw, input logic regw, input logic adr,
            input logic [1:0] rs, input logic [1:0] sb, input logic [1:0] ac,
            input logic [3:0] fl);
        return {st, pcw, irw, memw, regw, adr, rs, sb, ac, fl};
    endfunction

    task automatic push(input string n, input logic [18:0] v);
        sb_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
            input logic [5:0] f, input logic [3:0] r, input logic [3:0] af);
        cond = c; op = o; funct = f; rd = r; alu_flags = af;
    endtask

    // Drives mem_ready per cycle (bit i = cycle i); starts and ends 1ns after posedge
    task automatic run_cycles(input logic [15:0] mr, input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = mr[i];
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            exp_n = name_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", exp_n, obs, exp_v);
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        mem_ready = 1'b1;
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd0, 4'b0000);
        #3;
        checks++;
        if ({State, Flags, PCWrite, IRWrite, MemWrite, RegWrite} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got %h expected 000",
                     {State, Flags, PCWrite, IRWrite, MemWrite, RegWrite});
        end
        checks++;
        if ({ALUSrcA, ALUSrcB, ResultSrc, AdrSrc} !== 6'b110100) begin
            errors++;
            $display("FAIL reset_fetch_sel: got %b expected 110100",
                     {ALUSrcA, ALUSrcB, ResultSrc, AdrSrc});
        end
        @(posedge clk);
        #1;
        checks++;
        if (State !== 4'd0 || IRWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got state %0d irw %b expected 0 0", State, IRWrite);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_s();
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0100);
        push("add_fetch",  pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0000));
        push("add_decode", pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0000));
        push("add_exer",   pk(6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000));
        push("add_aluwb",  pk(8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'b0100));
        run_cycles(16'hFFFF, 4);
        checks++;
        if ({State, Flags} !== 8'h04) begin
            errors++;
            $display("FAIL add_done: got %h expected 04", {State, Flags});
        end
    endtask

    task automatic test_beq_taken();
        set_instr(4'b0000, 2'b10, 6'b101010, 4'd0, 4'b0000);
        #1;
        checks++;
        if ({ImmSrc, RegSrc} !== 4'b1001) begin
            errors++;
            $display("FAIL beq_sel: got %b expected 1001", {ImmSrc, RegSrc});
        end
        push("beqt_fetch",  pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0100));
        push("beqt_decode", pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0100));
        push("beqt_branch", pk(9, 1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'b0100));
        run_cycles(16'hFFFF, 3);
        checks++;
        if (State !== 4'd0) begin
            errors++;
            $display("FAIL beqt_done: got state %0d expected 0", State);
        end
    endtask

    task automatic test_orr_imm_pc();
        set_instr(4'b1110, 2'b00, 6'b111001, 4'd15, 4'b0010);
        push("orr_fetch",  pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0100));
        push("orr_decode", pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0100));
        push("orr_exei",   pk(7, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b11, 4'b0100));
        push("orr_aluwb",  pk(8, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'b0010));
        run_cycles(16'hFFFF, 4);
    endtask

    task automatic test_beq_not_taken();
        set_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b1111);
        push("beqn_fetch",  pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("beqn_decode", pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        run_cycles(16'hFFFF, 2);
        checks++;
        if ({State, Flags} !== 8'h02) begin
            errors++;
            $display("FAIL beqn_done: got %h expected 02", {State, Flags});
        end
    endtask

    task automatic test_ldr_wait();
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b1111);
        #1;
        checks++;
        if ({ImmSrc, RegSrc} !== 4'b0100) begin
            errors++;
            $display("FAIL ldr_sel: got %b expected 0100", {ImmSrc, RegSrc});
        end
        push("ldr_fetch",  pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("ldr_decode", pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("ldr_memadr", pk(2, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'b0010));
        for (int i = 0; i < 4; i++)
            push("ldr_memread", pk(3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0010));
        push("ldr_memwb",  pk(4, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 4'b0010));
        run_cycles(16'h0041, 8);
        checks++;
        if (State !== 4'd0) begin
            errors++;
            $display("FAIL ldr_done: got state %0d expected 0", State);
        end
    endtask

    task automatic test_fetch_stall();
        set_instr(4'b1110, 2'b00, 6'b100000, 4'd5, 4'b1111);
        push("stall_fetch0", pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("stall_fetch1", pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("stall_fetch2", pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("stall_decode", pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("stall_exei",   pk(7, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'b0010));
        push("stall_aluwb",  pk(8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'b0010));
        run_cycles(16'h003C, 6);
    endtask

    task automatic test_str();
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd3, 4'b1111);
        #1;
        checks++;
        if ({ImmSrc, RegSrc} !== 4'b0110) begin
            errors++;
            $display("FAIL str_sel: got %b expected 0110", {ImmSrc, RegSrc});
        end
        push("str_fetch",    pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("str_decode",   pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("str_memadr",   pk(2, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'b0010));
        push("str_memwrite", pk(5, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0010));
        run_cycles(16'hFFFF, 4);
        checks++;
        if ({State, MemWrite} !== 5'b00000) begin
            errors++;
            $display("FAIL str_done: got %b expected 00000", {State, MemWrite});
        end
    endtask

    task automatic test_cmp_gt();
        // CMP into R15 must still not write the PC
        set_instr(4'b1110, 2'b00, 6'b010101, 4'd15, 4'b1001);
        push("cmp1_fetch",  pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("cmp1_decode", pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0010));
        push("cmp1_exer",   pk(6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b0010));
        push("cmp1_aluwb",  pk(8, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b1001));
        run_cycles(16'hFFFF, 4);
        set_instr(4'b1100, 2'b00, 6'b001000, 4'd4, 4'b0000);
        push("gt1_fetch",  pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b1001));
        push("gt1_decode", pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b1001));
        push("gt1_exer",   pk(6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b1001));
        push("gt1_aluwb",  pk(8, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'b1001));
        run_cycles(16'hFFFF, 4);
        set_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0100);
        push("cmp2_fetch",  pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b1001));
        push("cmp2_decode", pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b1001));
        push("cmp2_exer",   pk(6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b1001));
        push("cmp2_aluwb",  pk(8, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0100));
        run_cycles(16'hFFFF, 4);
        set_instr(4'b1100, 2'b00, 6'b001000, 4'd4, 4'b1111);
        push("gt2_fetch",  pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0100));
        push("gt2_decode", pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0100));
        run_cycles(16'hFFFF, 2);
        checks++;
        if ({State, Flags} !== 8'h04) begin
            errors++;
            $display("FAIL gt2_skipped: got %h expected 04", {State, Flags});
        end
    endtask

    task automatic test_reset_mid_memwrite();
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd3, 4'b1111);
        push("rstw_fetch",    pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0100));
        push("rstw_decode",   pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 4'b0100));
        push("rstw_memadr",   pk(2, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'b0100));
        push("rstw_memwrite", pk(5, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0100));
        run_cycles(16'h0007, 4);
        #2;
        checks++;
        if ({State, MemWrite} !== 5'b01011) begin
            errors++;
            $display("FAIL rstw_pre: got %b expected 01011", {State, MemWrite});
        end
        reset_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({State, Flags, PCWrite, IRWrite, MemWrite, RegWrite} !== 12'h000) begin
            errors++;
            $display("FAIL rstw_async: got %h expected 000",
                     {State, Flags, PCWrite, IRWrite, MemWrite, RegWrite});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({State, PCWrite, IRWrite, MemWrite, RegWrite} !== 8'h00) begin
            errors++;
            $display("FAIL rstw_hold: got %h expected 00",
                     {State, PCWrite, IRWrite, MemWrite, RegWrite});
        end
        mem_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({State, Flags} !== 8'h00) begin
            errors++;
            $display("FAIL rstw_release: got %h expected 00", {State, Flags});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_s();
        test_beq_taken();
        test_orr_imm_pc();
        test_beq_not_taken();
        test_ldr_wait();
        test_fetch_stall();
        test_str();
        test_cmp_gt();
        test_reset_mid_memwrite();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
